barcode_rcv: RTL

Barcode station-ID receiver. Decodes the pulse-width-encoded serial stream from the barcode sensor into an 8-bit station ID. Presents it to the command processor on an `ID`/`ID_vld` handshake; the command processor acknowledges with `clr_ID_vld`. Sits directly upstream of the digital core's `ID`, `ID_vld` and `clr_ID_vld` ports.

---
 rtl/bc_pkg.sv | 20 ++
 rtl/bc_sync.sv | 32 +++
 rtl/barcode_rcv.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bc_pkg.sv
// Shared types and constants for the barcode station-ID receiver.
package bc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYNC_LOW  = 3'd1,
        WAIT_FALL = 3'd2,
        SAMPLE    = 3'd3,
        DONE      = 3'd4
    } bc_state_t;

    localparam int DEF_PERIOD_W = 22;
    localparam logic [1:0] ID_VALID_MSBS = 2'b00;

    // A station ID is accepted only when its two upper bits match the valid pattern.
    function automatic logic id_frame_ok(input logic [7:0] frame);
        return (frame[7:6] == ID_VALID_MSBS);
    endfunction

endpackage

// File: rtl/bc_sync.sv
// Two-flop synchronizer for the barcode line plus a history flop for edge detection.
module bc_sync (
    input  logic clk,
    input  logic rst,
    input  logic bc,
    output logic bc_s,
    output logic fall,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic hist_r;

    // Flops reset high (line idle level) so no spurious edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            hist_r <= 1'b1;
        end else begin
            meta_r <= bc;
            sync_r <= meta_r;
            hist_r <= sync_r;
        end
    end

    assign bc_s = sync_r;
    assign fall = hist_r & ~sync_r;
    assign rise = ~hist_r & sync_r;

endmodule

// File: rtl/barcode_rcv.sv
// Barcode station-ID receiver: measures the sync-bit period, samples 8 data bits
// at one period after each falling edge, and presents valid IDs on ID/ID_vld.
module barcode_rcv
    import bc_pkg::*;
#(
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int TIMEOUT_CYC = 4_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]     TO_MAX = TO_W'(TIMEOUT_CYC);
    localparam logic [PERIOD_W-1:0] P_MAX  = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W-1:0] P_ONE  = PERIOD_W'(1);

    logic bc_s;
    logic fall;
    logic rise;

    bc_state_t           state_r;
    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] t_r;
    logic [PERIOD_W-1:0] down_r;
    logic [TO_W-1:0]     timeout_r;
    logic [2:0]          bit_cnt_r;
    logic [7:0]          shift_r;

    bc_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .bc   (BC),
        .bc_s (bc_s),
        .fall (fall),
        .rise (rise)
    );

    // Frame decoder state machine with registered ID / ID_vld outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            period_r  <= '0;
            t_r       <= '0;
            down_r    <= '0;
            timeout_r <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            ID        <= 8'h00;
            ID_vld    <= 1'b0;
        end else begin
            // A set in DONE below overrides this clear when both happen together.
            if (clr_ID_vld) begin
                ID_vld <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (fall) begin
                        period_r  <= '0;
                        shift_r   <= 8'h00;
                        bit_cnt_r <= 3'd0;
                        state_r   <= SYNC_LOW;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SYNC_LOW: begin
                    if (rise) begin
                        t_r       <= period_r;
                        timeout_r <= '0;
                        state_r   <= WAIT_FALL;
                    end else if (period_r == P_MAX) begin
                        state_r   <= IDLE;
                    end else if (!bc_s) begin
                        period_r  <= period_r + P_ONE;
                    end else begin
                        state_r   <= SYNC_LOW;
                    end
                end
                WAIT_FALL: begin
                    if (fall) begin
                        down_r    <= t_r;
                        state_r   <= SAMPLE;
                    end else if (timeout_r == TO_MAX) begin
                        state_r   <= IDLE;
                    end else begin
                        timeout_r <= timeout_r + TO_W'(1);
                    end
                end
                SAMPLE: begin
                    // "<=" keeps a degenerate zero period from stalling here.
                    if (down_r <= P_ONE) begin
                        shift_r   <= {shift_r[6:0], bc_s};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        timeout_r <= '0;
                        state_r   <= (bit_cnt_r == 3'd7) ? DONE : WAIT_FALL;
                    end else begin
                        down_r    <= down_r - P_ONE;
                    end
                end
                DONE: begin
                    if (id_frame_ok(shift_r)) begin
                        ID     <= shift_r;
                        ID_vld <= 1'b1;
                    end else begin
                        ID     <= ID;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
